// File: rtl/tcdm_range_demux.sv
// Address-range demultiplexer: steers one TCDM master to N_PORTS slave buses,
// keeps responses in request order and answers unmapped addresses with an error.
module tcdm_range_demux #(
    parameter int unsigned N_PORTS         = 2,
    parameter int unsigned ADDR_WIDTH      = 32,
    parameter int unsigned DATA_WIDTH      = 32,
    parameter int unsigned MAX_OUTSTANDING = 2,
    parameter logic [N_PORTS-1:0][ADDR_WIDTH-1:0] START_ADDR = {32'h1C008000, 32'h1C000000},
    parameter logic [N_PORTS-1:0][ADDR_WIDTH-1:0] END_ADDR   = {32'h1C080000, 32'h1C008000}
) (
    input  logic                                clk_i,
    input  logic                                rst_ni,
    input  logic                                req_i,
    input  logic [ADDR_WIDTH-1:0]               add_i,
    input  logic                                wen_i,
    input  logic [DATA_WIDTH-1:0]               wdata_i,
    input  logic [DATA_WIDTH/8-1:0]             be_i,
    output logic                                gnt_o,
    output logic                                r_valid_o,
    output logic [DATA_WIDTH-1:0]               r_rdata_o,
    output logic                                r_err_o,
    output logic [N_PORTS-1:0]                  mst_req_o,
    output logic [ADDR_WIDTH-1:0]               mst_add_o,
    output logic                                mst_wen_o,
    output logic [DATA_WIDTH-1:0]               mst_wdata_o,
    output logic [DATA_WIDTH/8-1:0]             mst_be_o,
    input  logic [N_PORTS-1:0]                  mst_gnt_i,
    input  logic [N_PORTS-1:0]                  mst_r_valid_i,
    input  logic [N_PORTS-1:0][DATA_WIDTH-1:0]  mst_r_rdata_i,
    output logic                                busy_o
);
    localparam int unsigned TGT_W = $clog2(N_PORTS + 1);
    localparam int unsigned PTR_W = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
    localparam int unsigned CNT_W = $clog2(MAX_OUTSTANDING + 1);
    localparam logic [TGT_W-1:0] ERR_ID   = TGT_W'(N_PORTS);
    localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(MAX_OUTSTANDING - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(MAX_OUTSTANDING);

    logic [TGT_W-1:0] tgt_q [MAX_OUTSTANDING];
    logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0] count_q;
    logic [TGT_W-1:0] last_tgt_q;
    logic             err_pend_q;

    logic [TGT_W-1:0] sel;
    logic [TGT_W-1:0] head;
    logic             allow;
    logic             push;
    logic             pop;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] ptr);
        return (ptr == PTR_LAST) ? '0 : ptr + PTR_W'(1);
    endfunction

    // Lowest matching range index wins; no match targets the error pseudo-port.
    always_comb begin
        sel = ERR_ID;
        for (int p = int'(N_PORTS) - 1; p >= 0; p--) begin
            if ((add_i >= START_ADDR[p]) && (add_i < END_ADDR[p])) begin
                sel = TGT_W'(p);
            end
        end
    end

    // Only one target may be in flight at a time, which keeps responses ordered.
    always_comb begin
        allow = 1'b0;
        if (!rst_ni) begin
            allow = 1'b0;
        end else if (sel == ERR_ID) begin
            allow = (count_q == '0);
        end else begin
            allow = (count_q < CNT_MAX) && ((count_q == '0) || (sel == last_tgt_q));
        end
    end

    always_comb begin
        mst_req_o = '0;
        gnt_o     = 1'b0;
        if (sel == ERR_ID) begin
            gnt_o = allow;
        end else begin
            for (int p = 0; p < int'(N_PORTS); p++) begin
                if (sel == TGT_W'(p)) begin
                    mst_req_o[p] = req_i & allow;
                    gnt_o        = mst_gnt_i[p] & allow;
                end
            end
        end
    end

    assign mst_add_o   = add_i;
    assign mst_wen_o   = wen_i;
    assign mst_wdata_o = wdata_i;
    assign mst_be_o    = be_i;

    assign head = tgt_q[rd_ptr_q];

    // Response comes only from the head target; everything else is dropped.
    always_comb begin
        r_valid_o = 1'b0;
        r_rdata_o = '0;
        r_err_o   = 1'b0;
        if (count_q != '0) begin
            if (head == ERR_ID) begin
                r_valid_o = err_pend_q;
                r_err_o   = err_pend_q;
            end else begin
                for (int p = 0; p < int'(N_PORTS); p++) begin
                    if (head == TGT_W'(p)) begin
                        r_valid_o = mst_r_valid_i[p];
                        r_rdata_o = mst_r_rdata_i[p];
                    end
                end
            end
        end
    end

    assign push   = req_i & gnt_o;
    assign pop    = r_valid_o;
    assign busy_o = (count_q != '0);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < int'(MAX_OUTSTANDING); i++) begin
                tgt_q[i] <= '0;
            end
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            last_tgt_q <= '0;
            err_pend_q <= 1'b0;
        end else begin
            if (push) begin
                tgt_q[wr_ptr_q] <= sel;
                wr_ptr_q        <= ptr_inc(wr_ptr_q);
                last_tgt_q      <= sel;
            end
            if (pop) begin
                rd_ptr_q <= ptr_inc(rd_ptr_q);
            end
            if (push && !pop) begin
                count_q <= count_q + CNT_W'(1);
            end else if (pop && !push) begin
                count_q <= count_q - CNT_W'(1);
            end
            if (push && (sel == ERR_ID)) begin
                err_pend_q <= 1'b1;
            end else if (pop && (head == ERR_ID)) begin
                err_pend_q <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_tcdm_range_demux.sv
// Bench for tcdm_range_demux: directed scenarios plus randomized traffic, checked
// against a queue-based transaction model with slave behaviour modelled in the bench.
module tb_tcdm_range_demux;
    localparam int NP   = 2;
    localparam int MAXO = 2;
    localparam int ERR  = NP;
    localparam logic [31:0] R_LO [NP] = '{32'h1C000000, 32'h1C008000};
    localparam logic [31:0] R_HI [NP] = '{32'h1C008000, 32'h1C080000};

    typedef struct {
        bit          v;
        logic [31:0] a;
        bit          w;
        logic [31:0] d;
        logic [3:0]  b;
    } mreq_t;

    typedef struct {
        int          due;
        logic [31:0] data;
    } sresp_t;

    logic                 clk = 1'b0;
    logic                 rst_n;
    logic                 req;
    logic [31:0]          add;
    logic                 wen;
    logic [31:0]          wdata;
    logic [3:0]           be;
    logic                 gnt;
    logic                 r_valid;
    logic [31:0]          r_rdata;
    logic                 r_err;
    logic [NP-1:0]        mst_req;
    logic [31:0]          mst_add;
    logic                 mst_wen;
    logic [31:0]          mst_wdata;
    logic [3:0]           mst_be;
    logic [NP-1:0]        sgnt;
    logic [NP-1:0]        srv;
    logic [NP-1:0][31:0]  srdata;
    logic                 busy;

    mreq_t  mq[$];
    int     trk[$];
    sresp_t sq [NP][$];
    int     last_tgt;
    bit     err_pend;
    int     cyc;
    int     lat_min, lat_max, gnt_pct;
    bit     spur_en;
    int     n_assert;
    int     n_fail;

    tcdm_range_demux dut (
        .clk_i        (clk),
        .rst_ni       (rst_n),
        .req_i        (req),
        .add_i        (add),
        .wen_i        (wen),
        .wdata_i      (wdata),
        .be_i         (be),
        .gnt_o        (gnt),
        .r_valid_o    (r_valid),
        .r_rdata_o    (r_rdata),
        .r_err_o      (r_err),
        .mst_req_o    (mst_req),
        .mst_add_o    (mst_add),
        .mst_wen_o    (mst_wen),
        .mst_wdata_o  (mst_wdata),
        .mst_be_o     (mst_be),
        .mst_gnt_i    (sgnt),
        .mst_r_valid_i(srv),
        .mst_r_rdata_i(srdata),
        .busy_o       (busy)
    );

    always #5 clk = ~clk;

    function automatic int decode(input logic [31:0] a);
        for (int p = 0; p < NP; p++) begin
            if (a >= R_LO[p] && a < R_HI[p]) return p;
        end
        return ERR;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic add_req(input logic [31:0] a, input bit w);
        mreq_t m;
        m = '{v: 1'b1, a: a, w: w, d: $urandom(), b: 4'($urandom_range(15))};
        mq.push_back(m);
    endtask

    task automatic add_idle();
        mreq_t m;
        m = '{v: 1'b0, a: '0, w: 1'b0, d: '0, b: '0};
        mq.push_back(m);
    endtask

    function automatic logic [31:0] rand_addr();
        case ($urandom_range(9))
            0:       return 32'h1C007FFC;
            1:       return 32'h1C008000;
            2:       return 32'h1C07FFFC;
            3:       return 32'h1C080000;
            4:       return 32'h1BFFFFFC;
            5, 6:    return 32'h1C000000 + (32'($urandom_range(32'h1FFF)) << 2);
            7, 8:    return 32'h1C008000 + (32'($urandom_range(32'h1DFFF)) << 2);
            default: return 32'($urandom());
        endcase
    endfunction

    // One clock of traffic: drive at negedge, check after settling, update model at posedge.
    task automatic cycle();
        mreq_t         cur;
        int            sel, n, h;
        bit            allow, e_gnt, e_rv, e_err, push;
        logic [NP-1:0] e_req;
        logic [31:0]   e_rd;
        @(negedge clk);
        cur = '{v: 1'b0, a: '0, w: 1'b0, d: '0, b: '0};
        if (mq.size() > 0) cur = mq[0];
        req   = cur.v;
        add   = cur.v ? cur.a : 32'($urandom());
        wen   = cur.w;
        wdata = cur.d;
        be    = cur.b;
        for (int p = 0; p < NP; p++) begin
            sgnt[p] = ($urandom_range(99) < gnt_pct);
            if (sq[p].size() > 0 && sq[p][0].due <= cyc) begin
                srv[p]    = 1'b1;
                srdata[p] = sq[p][0].data;
            end else begin
                srv[p]    = spur_en && (sq[p].size() == 0) && ($urandom_range(3) == 0);
                srdata[p] = $urandom();
            end
        end
        #1;
        sel = decode(add);
        n   = trk.size();
        if (sel == ERR) allow = (n == 0);
        else            allow = (n < MAXO) && (n == 0 || sel == last_tgt);
        e_req = '0;
        e_gnt = 1'b0;
        if (sel == ERR) begin
            e_gnt = allow;
        end else begin
            e_req[sel] = req & allow;
            e_gnt      = allow & sgnt[sel];
        end
        e_rv  = 1'b0;
        e_err = 1'b0;
        e_rd  = '0;
        if (n > 0) begin
            h = trk[0];
            if (h == ERR) begin
                e_rv  = err_pend;
                e_err = err_pend;
            end else begin
                e_rv = srv[h];
                e_rd = e_rv ? sq[h][0].data : srdata[h];
            end
        end
        chk("mst_req", 64'(mst_req), 64'(e_req));
        chk("gnt", 64'(gnt), 64'(e_gnt));
        chk("r_valid", 64'(r_valid), 64'(e_rv));
        chk("r_rdata", 64'(r_rdata), 64'(e_rd));
        chk("r_err", 64'(r_err), 64'(e_err));
        chk("busy", 64'(busy), 64'(n != 0));
        chk("mst_add", 64'(mst_add), 64'(add));
        @(posedge clk);
        push = req & e_gnt;
        if (e_rv) begin
            h = trk.pop_front();
            if (h == ERR) err_pend = 1'b0;
            else          void'(sq[h].pop_front());
        end
        if (push) begin
            trk.push_back(sel);
            last_tgt = sel;
            if (sel == ERR) err_pend = 1'b1;
            else sq[sel].push_back('{due: cyc + int'($urandom_range(lat_max, lat_min)), data: $urandom()});
        end
        if (mq.size() > 0 && (push || !mq[0].v)) void'(mq.pop_front());
        cyc++;
    endtask

    task automatic run(input int k);
        repeat (k) cycle();
    endtask

    task automatic drain(input string tag, input int budget);
        int k;
        k = 0;
        while ((mq.size() > 0 || trk.size() > 0) && k < budget) begin
            cycle();
            k++;
        end
        chk(tag, 64'(mq.size() + trk.size()), 64'(0));
    endtask

    // Asserts reset with traffic present, checks quiet outputs, then releases
    // it while a stale slave response arrives.
    task automatic reset_check();
        @(negedge clk);
        rst_n  = 1'b0;
        req    = 1'b1;
        add    = 32'h1C000000;
        sgnt   = '1;
        srv    = '1;
        srdata = '1;
        #1;
        chk("rst_gnt", 64'(gnt), 64'(0));
        chk("rst_mst_req", 64'(mst_req), 64'(0));
        chk("rst_r_valid", 64'(r_valid), 64'(0));
        chk("rst_r_err", 64'(r_err), 64'(0));
        chk("rst_busy", 64'(busy), 64'(0));
        trk.delete();
        for (int p = 0; p < NP; p++) sq[p].delete();
        mq.delete();
        err_pend = 1'b0;
        last_tgt = 0;
        @(negedge clk);
        rst_n     = 1'b1;
        req       = 1'b0;
        srv       = '0;
        srv[0]    = 1'b1;
        srdata[0] = 32'hDEADBEEF;
        #1;
        chk("stale_r_valid", 64'(r_valid), 64'(0));
        chk("stale_r_rdata", 64'(r_rdata), 64'(0));
        chk("post_rst_busy", 64'(busy), 64'(0));
    endtask

    initial begin
        n_assert = 0;
        n_fail   = 0;
        cyc      = 0;
        rst_n    = 1'b0;
        req      = 1'b0;
        add      = '0;
        wen      = 1'b0;
        wdata    = '0;
        be       = '0;
        sgnt     = '0;
        srv      = '0;
        srdata   = '0;
        lat_min  = 1;
        lat_max  = 1;
        gnt_pct  = 100;
        spur_en  = 1'b0;
        err_pend = 1'b0;
        last_tgt = 0;

        reset_check();

        // Back-to-back reads to the same port with 1-cycle slave latency.
        add_req(32'h1C000000, 1'b1);
        add_req(32'h1C000004, 1'b1);
        run(5);

        // Port switch waits for the slow port-0 response.
        lat_min = 3;
        lat_max = 3;
        add_req(32'h1C000000, 1'b1);
        add_req(32'h1C010000, 1'b1);
        drain("drain_switch", 20);
        run(1);

        // Third read to port 1 stalls on the outstanding limit.
        lat_min = 4;
        lat_max = 4;
        add_req(32'h1C010000, 1'b1);
        add_req(32'h1C010004, 1'b1);
        add_req(32'h1C010008, 1'b1);
        drain("drain_limit", 30);
        run(1);

        // Unmapped write gets an internal error response one cycle later.
        add_req(32'h00000000, 1'b0);
        run(3);

        // Continuous same-port reads with simultaneous push/pop and pointer wrap.
        lat_min = 1;
        lat_max = 1;
        for (int i = 0; i < 8; i++) add_req(32'h1C000000 + 32'(i * 4), 1'b1);
        drain("drain_wrap", 20);
        run(1);

        // Randomized mixed traffic including range edges and unmapped addresses.
        lat_min = 1;
        lat_max = 4;
        gnt_pct = 70;
        spur_en = 1'b1;
        for (int i = 0; i < 300; i++) begin
            if ($urandom_range(99) < 15) add_idle();
            else add_req(rand_addr(), 1'($urandom_range(1)));
        end
        drain("drain_random", 5000);

        // Reset with two requests outstanding.
        spur_en = 1'b0;
        gnt_pct = 100;
        lat_min = 8;
        lat_max = 8;
        add_req(32'h1C000000, 1'b1);
        add_req(32'h1C000004, 1'b1);
        run(3);
        reset_check();
        lat_min = 1;
        lat_max = 1;
        add_req(32'h1C008000, 1'b1);
        drain("drain_after_rst", 20);
        run(2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/tcdm_range_demux.md
# tcdm_range_demux

Parametrised address-decoding demultiplexer. It steers one TCDM-style master (core instruction or data port) to N_PORTS slave buses, each selected by a parameterised address range. It tracks up to MAX_OUTSTANDING in-flight requests so that responses always return in request order, and it answers unmapped addresses with an internally generated error response. It sits between the FC core and the L2/SCM/peripheral interconnect ports in the FC subsystem, and generalises the two-port L2/SCM split.

## Interface
- N_PORTS, 2: number of slave ports (1..8).
- ADDR_WIDTH, 32: address width.
- DATA_WIDTH, 32: data width; BE width is DATA_WIDTH/8.
- MAX_OUTSTANDING, 2: in-flight request limit (1..8).
- START_ADDR, {0x1C008000, 0x1C000000}: [N_PORTS][ADDR_WIDTH] inclusive range starts; index 0 is the rightmost entry.
- END_ADDR, {0x1C080000, 0x1C008000}: [N_PORTS][ADDR_WIDTH] exclusive range ends.
- clk_i  in  1  clock; one clock domain. Reset is asynchronous and active-low.
- rst_ni  in  1  asynchronous active-low reset.
- req_i, add_i[ADDR_WIDTH], wen_i (1 = read), wdata_i[DATA_WIDTH], be_i  in  request from the master.
- gnt_o  out  1  request accepted.
- r_valid_o  out  1  response valid.
- r_rdata_o  out  DATA_WIDTH  response data.
- r_err_o  out  1  decode error on this response.
- mst_req_o[N_PORTS]  out  per-port request.
- mst_add_o, mst_wen_o, mst_wdata_o, mst_be_o  out  broadcast to all ports.
- mst_gnt_i[N_PORTS], mst_r_valid_i[N_PORTS], mst_r_rdata_i[N_PORTS][DATA_WIDTH]  in  per-port grant and response.
- busy_o  out  1  one or more requests outstanding.

## Operation
- **Decode.** sel is the lowest index p with START_ADDR[p] <= add_i < END_ADDR[p]. If no range matches, the target is ERR (pseudo-port N_PORTS).
- **Tracker.** A circular FIFO of depth MAX_OUTSTANDING stores the target id of each granted request. It has rd/wr pointers, a count of width $clog2(MAX_OUTSTANDING+1), and a last_tgt register holding the id of the most recent push.
- **Issue condition (allow).**
  - For a mapped port: count < MAX_OUTSTANDING, and either count == 0 or sel == last_tgt.
  - For ERR: count == 0 only.
- **Forwarding.**
  - mst_req_o[sel] = req_i & allow.
  - gnt_o = mst_gnt_i[sel] & allow for a mapped port; gnt_o = allow for ERR.
  - All other mst_req_o are 0.
  - Push on req_i & gnt_o.
- **Stall.** If allow = 0, gnt_o = 0 and no mst_req_o is asserted. The master holds its request (TCDM protocol).
- **Response for a mapped head.**
  - r_valid_o = mst_r_valid_i[head].
  - r_rdata_o = mst_r_rdata_i[head].
  - r_err_o = 0.
  - Pop on r_valid_o.
- **Response for an ERR head.**
  - The err_pend flop is set by an ERR grant.
  - The following cycle gives r_valid_o = 1, r_rdata_o = 0, r_err_o = 1; this pops the entry and clears err_pend.
- **Response filtering.**
  - mst_r_valid_i from a port that is not head is ignored.
  - When count == 0, r_valid_o = 0 and r_rdata_o = 0.
- **Simultaneous events.** A push and a pop in the same cycle leave count unchanged, and both pointers advance modulo MAX_OUTSTANDING.
- **Outputs.** busy_o = (count != 0).
- **Reset.** Pointers, count, last_tgt and err_pend are all 0.
  - r_valid_o, r_err_o, gnt_o, mst_req_o and busy_o are 0 during reset.
  - A reset mid-transaction discards outstanding entries; late slave responses after reset are ignored because count == 0.

## Timing
- Request path is combinational: req_i → mst_req_o, and mst_gnt_i → gnt_o, in the same cycle.
- Mapped-port response is a combinational passthrough, so response latency equals the slave latency.
- ERR response arrives exactly 1 cycle after the grant.
- Port switch: the first request to a new port is granted no earlier than the cycle in which the last outstanding response to the old port is returned.
- Throughput: 1 request per cycle to the same port while count < MAX_OUTSTANDING.
- The only registered state is the tracker and err_pend; no output is registered except the ERR response.

## Test plan
- **Back-to-back same port.** Reads to 0x1C000000 and 0x1C000004; slave gnt = 1, response 1 cycle later.
  - Expect both granted on consecutive cycles.
  - Expect r_rdata in order; busy_o falls after the second response.
- **Port switch stall.** Read 0x1C000000 (port 0, response delayed 3 cycles), then read 0x1C010000 (port 1).
  - Expect mst_req_o[1] = 0 until the port-0 response cycle.
  - Then expect the grant and the ordered response.
- **Outstanding limit.** MAX_OUTSTANDING = 2; three reads to port 1 with responses held off.
  - Expect the third gnt_o = 0 until the first response.
  - Expect count never to exceed 2.
- **Decode error.** Write to 0x00000000 while idle.
  - Expect gnt_o = 1 the same cycle.
  - Next cycle expect r_valid_o = 1, r_err_o = 1, r_rdata_o = 0.
  - Expect no mst_req_o asserted.
- **Simultaneous push/pop and wraparound.** Eight consecutive port-0 reads at 1-cycle slave latency.
  - Expect continuous grants, pointers wrapping, count staying at 1, and data in order.
- **Reset mid-operation.** Assert rst_ni low with 2 outstanding requests, then release.
  - Expect busy_o = 0, and a stale mst_r_valid_i[0] to produce no r_valid_o.
